// File: rtl/wishbone_initiator_bfm.sv
// Wishbone classic initiator engine: runs one command per bus cycle,
// then forces one idle cycle before the next strobe.
module wishbone_initiator_bfm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_r,
  output logic [DATA_WIDTH-1:0]   dat_w,
  output logic                    stb,
  output logic                    cyc,
  input  logic                    ack,
  output logic                    we,
  output logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESET,
    ACTIVE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   issue;
  logic   term;

  // A command may be taken in IDLE or in the single DONE cycle;
  // either way the strobe rises only after the idle cycle.
  assign cmd_ready = (state_q == IDLE) || (state_q == DONE);
  assign issue     = cmd_valid && cmd_ready;
  // ack/err only count while the cycle is open (ACTIVE).
  assign term      = (state_q == ACTIVE) && (ack || err);

  // State register; reset parks the engine until a clean edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_RESET: state_d = IDLE;
      IDLE:       state_d = issue ? ACTIVE : IDLE;
      DONE:       state_d = issue ? ACTIVE : IDLE;
      ACTIVE:     state_d = term ? DONE : ACTIVE;
      default:    state_d = WAIT_RESET;
    endcase
  end

  // Bus outputs and response capture. rsp_err resets high so a
  // caller caught by reset sees an aborted (error) result, data 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      sel       <= '0;
      dat_w     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b1;
      rsp_dat   <= '0;
    end else begin
      rsp_valid <= term;
      if (issue) begin
        cyc <= 1'b1;
        stb <= 1'b1;
        we  <= cmd_we;
        adr <= cmd_adr;
        sel <= cmd_sel;
        if (cmd_we) begin
          dat_w <= cmd_dat;
        end
      end
      if (term) begin
        cyc     <= 1'b0;
        stb     <= 1'b0;
        we      <= 1'b0;
        rsp_err <= err;
        rsp_dat <= we ? '0 : dat_r;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_initiator_bfm.sv
// Bench for wishbone_initiator_bfm: blocking write/read procedures,
// a registered-ack target and an address-level reference memory.
`timescale 1ns/1ps
module tb_wishbone_initiator_bfm;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] adr;
  logic [31:0] dat_r;
  logic [31:0] dat_w;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        we;
  logic [3:0]  sel;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_initiator_bfm #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_dat(rsp_dat),
    .adr(adr), .dat_r(dat_r), .dat_w(dat_w),
    .stb(stb), .cyc(cyc), .ack(ack), .we(we),
    .sel(sel), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- target ----------------
  logic [31:0] tgt_mem [0:4095];
  logic        resp_q;
  int          cnt;
  int          wait_cur;
  int          wait_max  = 0;
  bit          rand_wait = 0;
  logic        spur_ack  = 1'b0;
  logic        spur_err  = 1'b0;
  logic        t_err;
  logic        t_ack;
  logic [31:0] wtmp;

  assign t_err = (adr == 32'h2000) || (adr == 32'h3000);
  assign t_ack = (adr != 32'h2000);
  assign ack   = (resp_q & stb & cyc & t_ack) | spur_ack;
  assign err   = (resp_q & stb & cyc & t_err) | spur_err;
  assign dat_r = tgt_mem[adr[13:2]];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_q <= 1'b0;
      cnt    <= 0;
    end else begin
      if (resp_q && stb && cyc && we && !t_err) begin
        wtmp = tgt_mem[adr[13:2]];
        for (int i = 0; i < 4; i++)
          if (sel[i]) wtmp[8*i +: 8] = dat_w[8*i +: 8];
        tgt_mem[adr[13:2]] <= wtmp;
      end
      if (stb && cyc && !resp_q) begin
        if (cnt >= wait_cur) resp_q <= 1'b1;
        else cnt <= cnt + 1;
      end else begin
        resp_q   <= 1'b0;
        cnt      <= 0;
        wait_cur <= rand_wait ?
          int'($urandom_range(0, wait_max)) : wait_max;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic        prev_stb = 1'b0;
  int          idle_run = 1000;
  int          last_gap = 0;
  int          min_gap  = 1000;
  int          cur_len  = 0;
  int          n_xfer   = 0;
  int          unstable = 0;
  int          cs_bad   = 0;
  int          early    = 0;
  logic [31:0] rec_adr, rec_dat;
  logic [3:0]  rec_sel;
  logic        rec_we;
  time         first_rise = 0;

  always @(posedge stb)
    if (first_rise == 0) first_rise = $time;

  always @(negedge clock) begin
    if (cyc !== stb) cs_bad++;
    if (stb === 1'b1) begin
      if (!prev_stb) begin
        n_xfer++;
        last_gap = idle_run;
        if (idle_run < min_gap) min_gap = idle_run;
        if (ack === 1'b1 && !spur_ack) early++;
        rec_adr = adr; rec_we = we;
        rec_sel = sel; rec_dat = dat_w;
        cur_len = 0;
      end else if (adr !== rec_adr || we !== rec_we ||
                   sel !== rec_sel || dat_w !== rec_dat) begin
        unstable++;
      end
      cur_len++;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_stb = stb;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0]  s);
    logic [31:0] v;
    v = ref_rd(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    ref_mem[a] = v;
  endfunction

  // ---------------- command API ----------------
  int next_ticket = 0;
  int serving     = 0;

  task automatic bfm_xfer(input  logic        w,
                          input  logic [31:0] a,
                          input  logic [31:0] d,
                          input  logic [3:0]  s,
                          output logic [31:0] rd,
                          output logic        e);
    int my;
    int budget;
    my = next_ticket;
    next_ticket++;
    wait (serving == my);
    @(negedge clock);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    cmd_valid = 1'b1;
    budget = 0;
    while (!(cmd_ready === 1'b1 && reset === 1'b0) && budget < 500) begin
      @(negedge clock);
      budget++;
    end
    rd = 32'h0;
    e  = 1'b1;
    if (budget >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: adr %h not taken", a);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      budget = 0;
      while (budget < 500) begin
        @(negedge clock);
        if (reset === 1'b1 || rsp_valid === 1'b1) begin
          rd = rsp_dat;
          e  = rsp_err;
          break;
        end
        budget++;
      end
      if (budget >= 500) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_timeout: adr %h no termination", a);
      end
    end
    serving++;
  endtask

  task automatic bfm_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic e);
    logic [31:0] dummy;
    bfm_xfer(1'b1, a, d, s, dummy, e);
  endtask

  task automatic bfm_read(input logic [31:0] a, input logic [3:0] s,
                          output logic [31:0] d, output logic e);
    bfm_xfer(1'b0, a, 32'h0, s, d, e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic e;
    fork
      bfm_write(32'h1000, 32'hDEADBEEF, 4'hF, e);
      begin
        #20;
        n_checks++;
        if ({cyc, stb, we} !== 3'b000) begin
          n_fail++;
          $display("FAIL rst_ctl: cyc/stb/we %b want 000", {cyc, stb, we});
        end
        n_checks++;
        if (adr !== 32'h0 || sel !== 4'h0) begin
          n_fail++;
          $display("FAIL rst_adr_sel: adr %h sel %h want 0", adr, sel);
        end
        n_checks++;
        if (dat_w !== 32'h0) begin
          n_fail++;
          $display("FAIL rst_dat_w: got %h want 0", dat_w);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_ready: got %b want 0", cmd_ready);
        end
        #30 reset = 1'b0;
      end
    join
    if (e === 1'b0) ref_wr(32'h1000, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (!(first_rise > 55)) begin
      n_fail++;
      $display("FAIL first_stb: rose at %0t want after 55", first_rise);
    end
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++;
      $display("FAIL wr1_err: got %b want 0", e);
    end
    n_checks++;
    if (rec_adr !== 32'h1000 || rec_we !== 1'b1 || rec_sel !== 4'hF ||
        rec_dat !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr1_bus: adr %h we %b sel %h dat %h",
               rec_adr, rec_we, rec_sel, rec_dat);
    end
    n_checks++;
    if (cur_len !== 2) begin
      n_fail++;
      $display("FAIL wr1_len: stb cycles %0d want 2", cur_len);
    end
    n_checks++;
    if (cyc !== 1'b0 || stb !== 1'b0) begin
      n_fail++;
      $display("FAIL wr1_drop: cyc %b stb %b want 0", cyc, stb);
    end
  endtask

  task automatic test_read_after_write;
    logic [31:0] d;
    logic        e;
    bfm_read(32'h1000, 4'hF, d, e);
    n_checks++;
    if (d !== ref_rd(32'h1000) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd1: got %h err %b want %h err 0",
               d, e, ref_rd(32'h1000));
    end
    n_checks++;
    if (rec_we !== 1'b0 || last_gap < 1) begin
      n_fail++;
      $display("FAIL rd1_bus: we %b gap %0d want 0 / >=1",
               rec_we, last_gap);
    end
    n_checks++;
    if (dat_w !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL dat_w_hold: got %h want deadbeef", dat_w);
    end
  endtask

  task automatic test_back_to_back;
    int          x0;
    int          got;
    int          bad;
    logic [31:0] d;
    logic        e;
    x0 = n_xfer;
    min_gap = 1000;
    got = 0;
    bad = 0;
    fork
      begin
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
          cmd_we = 1'b1;
          cmd_adr = 32'h1000 + 32'(4 * i);
          cmd_dat = 32'h5000_0000 + 32'(i);
          cmd_sel = 4'hF;
          cmd_valid = 1'b1;
          for (int b = 0; b < 100 && cmd_ready !== 1'b1; b++)
            @(negedge clock);
          @(posedge clock);
          #1;
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int b = 0; b < 400 && got < 10; b++) begin
          @(negedge clock);
          if (rsp_valid === 1'b1) begin
            if (rsp_err !== 1'b0) bad++;
            else ref_wr(32'h1000 + 32'(4 * got),
                        32'h5000_0000 + 32'(got), 4'hF);
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got !== 10 || bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_rsp: got %0d bad %0d want 10 / 0", got, bad);
    end
    n_checks++;
    if (n_xfer - x0 !== 10) begin
      n_fail++;
      $display("FAIL b2b_count: %0d want 10", n_xfer - x0);
    end
    n_checks++;
    if (min_gap < 1) begin
      n_fail++;
      $display("FAIL b2b_gap: min idle %0d want >=1", min_gap);
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL early_ack: %0d want 0", early);
    end
    for (int i = 0; i < 10; i++) begin
      bfm_read(32'h1000 + 32'(4 * i), 4'hF, d, e);
      n_checks++;
      if (d !== ref_rd(32'h1000 + 32'(4 * i)) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_rd%0d: got %h err %b want %h",
                 i, d, e, ref_rd(32'h1000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_error;
    logic [31:0] d;
    logic        e;
    bfm_write(32'h2000, 32'h1234_5678, 4'hF, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL err_wr: got %b want 1", e);
    end
    n_checks++;
    if (cyc !== 1'b0 || stb !== 1'b0) begin
      n_fail++;
      $display("FAIL err_drop: cyc %b stb %b want 0", cyc, stb);
    end
    bfm_read(32'h3000, 4'hF, d, e);
    n_checks++;
    if (e !== 1'b1 || d !== ref_rd(32'h3000)) begin
      n_fail++;
      $display("FAIL ackerr_rd: got %h err %b want %h err 1",
               d, e, ref_rd(32'h3000));
    end
  endtask

  task automatic test_spurious;
    int          seen;
    logic [31:0] d;
    logic        e;
    seen = 0;
    @(negedge clock);
    spur_ack = 1'b1;
    spur_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1 || cyc === 1'b1) seen++;
    end
    spur_ack = 1'b0;
    spur_err = 1'b0;
    @(negedge clock);
    if (rsp_valid === 1'b1) seen++;
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL spurious: reacted %0d times want 0", seen);
    end
    bfm_write(32'h1030, 32'hC0FF_EE00, 4'h5, e);
    if (e === 1'b0) ref_wr(32'h1030, 32'hC0FF_EE00, 4'h5);
    bfm_read(32'h1030, 4'hF, d, e);
    n_checks++;
    if (d !== ref_rd(32'h1030) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_rd: got %h err %b want %h",
               d, e, ref_rd(32'h1030));
    end
  endtask

  task automatic test_random;
    logic [31:0] a, dd, d;
    logic [3:0]  s;
    logic        e;
    rand_wait = 1;
    wait_max  = 3;
    for (int i = 0; i < 40; i++) begin
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      dd = $urandom;
      s  = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        bfm_write(a, dd, s, e);
        if (e === 1'b0) ref_wr(a, dd, s);
        n_checks++;
        if (e !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_wr%0d: err %b want 0", i, e);
        end
      end else begin
        bfm_read(a, s, d, e);
        n_checks++;
        if (d !== ref_rd(a) || e !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_rd%0d: adr %h got %h err %b want %h",
                   i, a, d, e, ref_rd(a));
        end
      end
    end
    rand_wait = 0;
    wait_max  = 0;
  endtask

  task automatic test_concurrent;
    logic [31:0] d;
    logic        e1, e2, e;
    fork
      bfm_write(32'h1040, 32'hAAAA_0001, 4'hF, e1);
      bfm_write(32'h1044, 32'hBBBB_0002, 4'hF, e2);
    join
    if (e1 === 1'b0) ref_wr(32'h1040, 32'hAAAA_0001, 4'hF);
    if (e2 === 1'b0) ref_wr(32'h1044, 32'hBBBB_0002, 4'hF);
    n_checks++;
    if (e1 !== 1'b0 || e2 !== 1'b0 || unstable !== 0 || cs_bad !== 0) begin
      n_fail++;
      $display("FAIL conc: e1 %b e2 %b unstable %0d cyc!=stb %0d",
               e1, e2, unstable, cs_bad);
    end
    bfm_read(32'h1044, 4'hF, d, e);
    n_checks++;
    if (d !== ref_rd(32'h1044)) begin
      n_fail++;
      $display("FAIL conc_rd: got %h want %h", d, ref_rd(32'h1044));
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] d;
    logic        e;
    int          b;
    wait_max = 8;
    fork
      bfm_read(32'h1000, 4'hF, d, e);
      begin
        b = 0;
        while (stb !== 1'b1 && b < 100) begin
          @(negedge clock);
          b++;
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({cyc, stb, we} !== 3'b000 || adr !== 32'h0 ||
            sel !== 4'h0 || dat_w !== 32'h0) begin
          n_fail++;
          $display("FAIL abort_out: cyc %b stb %b we %b adr %h sel %h dw %h",
                   cyc, stb, we, adr, sel, dat_w);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
      end
    join
    wait_max = 0;
    n_checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_rsp: got %h err %b want 0 err 1", d, e);
    end
    bfm_write(32'h1008, 32'h600D_F00D, 4'hF, e);
    if (e === 1'b0) ref_wr(32'h1008, 32'h600D_F00D, 4'hF);
    n_checks++;
    if (e !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_wr: err %b want 0", e);
    end
    bfm_read(32'h1008, 4'hF, d, e);
    n_checks++;
    if (d !== ref_rd(32'h1008) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_rd: got %h want %h", d, ref_rd(32'h1008));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    for (int i = 0; i < 4096; i++) tgt_mem[i] = 32'h0;
    tgt_mem[12'hC00] = 32'hA5A5_5A5A;
    ref_mem[32'h3000] = 32'hA5A5_5A5A;
    test_reset;
    test_read_after_write;
    test_back_to_back;
    test_error;
    test_spurious;
    test_random;
    test_concurrent;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
